sram_be: RTL and testbench

- Single-port synchronous SRAM, 8192 words x 32 bits, with per-byte write enables and registered read data.
- Used as on-chip instruction/data memory behind the CPU memory interface.
- Behaves like an FPGA block-RAM single-port macro: one access port and one clock.

---
 rtl/sram_pkg.sv | 12 +
 rtl/sram_lane.sv | 29 ++
 rtl/sram_be.sv | 29 ++
 tb/tb_sram_be.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared sizing constants and types for the byte-enabled single-port SRAM.
package sram_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NBYTES = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NBYTES-1:0] byteen_t;

endpackage

// File: rtl/sram_lane.sv
// One 8-bit byte lane: single-port RAM with registered read data.
module sram_lane
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = sram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  input  logic              we,
  input  logic              re,
  output logic [7:0]        q
);

  logic [7:0] mem [2**ADDR_W];

  // Both updates are non-blocking, so a same-edge read sees the pre-write byte.
  // Reset suppresses the write but never clears the array contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      if (re) q <= mem[addr];
      if (we) mem[addr] <= data;
    end
  end

endmodule

// File: rtl/sram_be.sv
// 8192 x 32 single-port SRAM with per-byte write enables, built from byte lanes.
module sram_be
  import sram_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  addr_t   addr,
  input  byteen_t byteen,
  input  word_t   data,
  input  logic    rden,
  input  logic    wren,
  output word_t   q
);

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    sram_lane #(
      .ADDR_W(ADDR_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .addr(addr),
      .data(data[8*i +: 8]),
      .we  (wren & byteen[i]),
      .re  (rden),
      .q   (q[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_sram_be.sv
// Self-checking bench for sram_be: directed vector table plus randomized model check.
module tb_sram_be;
  import sram_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b0;
  addr_t   addr = '0;
  byteen_t byteen = '0;
  word_t   data = '0;
  logic    rden = 1'b0;
  logic    wren = 1'b0;
  word_t   q;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sram_be dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .byteen(byteen),
    .data  (data),
    .rden  (rden),
    .wren  (wren),
    .q     (q)
  );

  always #5 clk = ~clk;

  // Reference model: sparse word store and the word the port should present.
  word_t mdl_mem [int];
  word_t mdl_q = '0;

  typedef struct {
    logic    rst;
    addr_t   addr;
    byteen_t be;
    word_t   data;
    logic    rd;
    logic    wr;
    word_t   exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, int unsigned a, logic [3:0] be, logic [31:0] d,
                              logic rd, logic wr, logic [31:0] e);
    vec_t v;
    v.rst = r; v.addr = addr_t'(a); v.be = be; v.data = d;
    v.rd = rd; v.wr = wr; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // One clock cycle of access; the model is advanced from the same inputs.
  task automatic cycle(input logic r, input addr_t a, input byteen_t be, input word_t d,
                       input logic rd, input logic wr);
    word_t old, nw;
    rst = r; addr = a; byteen = be; data = d; rden = rd; wren = wr;
    @(posedge clk);
    if (r) begin
      mdl_q = '0;
    end else begin
      old = mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 'x;
      if (rd) mdl_q = old;
      if (wr) begin
        nw = old;
        for (int b = 0; b < 4; b++)
          if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
        mdl_mem[int'(a)] = nw;
      end
    end
    #1;
  endtask

  initial begin
    vecs.push_back(mk(1, 0,    4'hF, 32'h0000_0000, 1, 1, 32'h0000_0000)); // reset state
    vecs.push_back(mk(0, 0,    4'hF, 32'h1234_5678, 0, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 1,    4'hF, 32'h1234_5678, 0, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 0,    4'hF, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'h8, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'h4, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'h2, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'h1, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'hA, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'hC, 32'h9876_dead, 0, 1, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'hF, 32'h0,         1, 0, 32'h9876_5678));
    vecs.push_back(mk(0, 0,    4'h3, 32'hdead_5432, 0, 1, 32'h9876_5678));
    vecs.push_back(mk(0, 0,    4'hF, 32'h0,         1, 0, 32'h9876_5432));
    vecs.push_back(mk(0, 1,    4'hF, 32'h0,         1, 0, 32'h1234_5678));
    vecs.push_back(mk(0, 0,    4'hF, 32'haabb_ccdd, 1, 1, 32'h9876_5432)); // read-before-write
    vecs.push_back(mk(0, 0,    4'hF, 32'h0,         1, 0, 32'haabb_ccdd));
    vecs.push_back(mk(0, 1,    4'hF, 32'h5555_5555, 0, 0, 32'haabb_ccdd));
    vecs.push_back(mk(0, 2,    4'h0, 32'h6666_6666, 0, 0, 32'haabb_ccdd));
    vecs.push_back(mk(0, 3,    4'hF, 32'h7777_7777, 0, 0, 32'haabb_ccdd));
    vecs.push_back(mk(1, 0,    4'hF, 32'h1111_1111, 1, 1, 32'h0000_0000)); // reset blocks write
    vecs.push_back(mk(0, 0,    4'hF, 32'h0,         1, 0, 32'haabb_ccdd));
    vecs.push_back(mk(0, 0,    4'h0, 32'hffff_ffff, 0, 1, 32'haabb_ccdd)); // empty byteen
    vecs.push_back(mk(0, 0,    4'hF, 32'h0,         1, 0, 32'haabb_ccdd));
    vecs.push_back(mk(0, 8191, 4'hF, 32'hcafe_f00d, 0, 1, 32'haabb_ccdd));
    vecs.push_back(mk(0, 8191, 4'hF, 32'h0,         1, 0, 32'hcafe_f00d));
    vecs.push_back(mk(0, 1,    4'hF, 32'h0,         1, 0, 32'h1234_5678));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].rd, vecs[i].wr);
      check($sformatf("vec%0d", i), q, vecs[i].exp);
    end

    // Back-to-back: partial write then immediate read of the same word, then another word.
    cycle(0, addr_t'(8190), 4'hF, 32'h0102_0304, 0, 1);
    cycle(0, addr_t'(8190), 4'h5, 32'hf0e0_d0c0, 0, 1);
    cycle(0, addr_t'(8190), 4'h0, 32'h0,         1, 0);
    check("b2b_partial", q, 32'h01e0_03c0);
    cycle(0, addr_t'(8191), 4'h0, 32'h0,         1, 0);
    check("b2b_next", q, 32'hcafe_f00d);

    // Randomized traffic over the low and high ends of the address space.
    for (int k = 0; k < 16; k++) begin
      cycle(0, addr_t'(k), 4'hF, $urandom, 0, 1);
      cycle(0, addr_t'(8191 - k), 4'hF, $urandom, 0, 1);
    end
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      addr_t a;
      r = $urandom_range(0, 15);
      a = ($urandom_range(0, 1) == 1) ? addr_t'(r) : addr_t'(8191 - r);
      cycle(($urandom_range(0, 39) == 0), a, byteen_t'($urandom_range(0, 15)), $urandom,
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      check($sformatf("rand%0d", n), q, mdl_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
